pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 33 +++
 rtl/pc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the PC sequencer and its surrounding fetch logic.
// The master side raises requests and owns the PC register; the slave side is the sequencer.
interface pc_sequencer_if;
  localparam int unsigned PC_W = 4;

  logic [PC_W-1:0] pc_value;
  logic            stall;
  logic            halt_req;
  logic            resume_req;
  logic            jump_req;
  logic [PC_W-1:0] jump_addr;
  logic            irq_req;
  logic            iret_req;
  logic            call_req;
  logic            ret_req;
  logic            pc_load;
  logic [PC_W-1:0] pc_load_value;
  logic            irq_ack;
  logic            stk_err;
  logic [1:0]      state;

  modport master (
    output pc_value, stall, halt_req, resume_req, jump_req, jump_addr,
           irq_req, iret_req, call_req, ret_req,
    input  pc_load, pc_load_value, irq_ack, stk_err, state
  );

  modport slave (
    input  pc_value, stall, halt_req, resume_req, jump_req, jump_addr,
           irq_req, iret_req, call_req, ret_req,
    output pc_load, pc_load_value, irq_ack, stk_err, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: picks one PC action per cycle (boot, irq, iret, call/ret, jump, halt, stall, increment).
// Define PC_SEQ_RETSTACK_EN to build in the 4-entry subroutine return stack.
module pc_sequencer #(
  parameter logic [3:0] BOOT_ADDR  = 4'h0,
  parameter logic [3:0] IRQ_VECTOR = 4'hC
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  localparam int unsigned PC_W = 4;

  localparam logic [1:0] ST_BOOT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_IRQ  = 2'b10;
  localparam logic [1:0] ST_HALT = 2'b11;

  logic [1:0]      state_q, state_d;
  logic [1:0]      hret_q, hret_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic [PC_W-1:0] pc_inc;

  logic            pc_load_c;
  logic [PC_W-1:0] pc_load_value_c;
  logic            irq_ack_c;
  logic            stk_err_c;

  assign pc_inc = bus.pc_value + PC_W'(1);

`ifdef PC_SEQ_RETSTACK_EN
  localparam int unsigned STK_DEPTH = 4;
  localparam int unsigned STK_IDX_W = 2;
  localparam int unsigned SP_W      = 3;

  logic [PC_W-1:0] stk_q [STK_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic            push_c;
  logic            stk_full;
  logic            stk_empty;
  logic [PC_W-1:0] stk_top;

  assign stk_full  = (sp_q == SP_W'(STK_DEPTH));
  assign stk_empty = (sp_q == SP_W'(0));
  assign stk_top   = stk_q[STK_IDX_W'(sp_q - SP_W'(1))];

  // Return stack storage; sp counts valid entries, push writes slot sp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q <= '0;
      for (int i = 0; i < int'(STK_DEPTH); i++) stk_q[i] <= '0;
    end else begin
      sp_q <= sp_d;
      if (push_c) stk_q[STK_IDX_W'(sp_q)] <= pc_inc;
    end
  end
`endif

  // State, exception return PC and halt-return state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      hret_q  <= ST_RUN;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      hret_q  <= hret_d;
      epc_q   <= epc_d;
    end
  end

  // Next-state and zero-latency PC control; one action per cycle in priority order.
  always_comb begin
    state_d         = state_q;
    hret_d          = hret_q;
    epc_d           = epc_q;
    pc_load_c       = 1'b0;
    pc_load_value_c = bus.pc_value;
    irq_ack_c       = 1'b0;
    stk_err_c       = 1'b0;
`ifdef PC_SEQ_RETSTACK_EN
    push_c          = 1'b0;
    sp_d            = sp_q;
`endif

    case (state_q)
      ST_BOOT: begin
        pc_load_c       = 1'b1;
        pc_load_value_c = BOOT_ADDR;
        state_d         = ST_RUN;
      end

      ST_HALT: begin
        pc_load_c = 1'b1;
        if (bus.resume_req) state_d = hret_q;
      end

      default: begin
        if (bus.irq_req && (state_q == ST_RUN)) begin
          pc_load_c       = 1'b1;
          pc_load_value_c = IRQ_VECTOR;
          epc_d           = pc_inc;
          irq_ack_c       = 1'b1;
          state_d         = ST_IRQ;
        end else if (bus.iret_req && (state_q == ST_IRQ)) begin
          pc_load_c       = 1'b1;
          pc_load_value_c = epc_q;
          state_d         = ST_RUN;
        end
`ifdef PC_SEQ_RETSTACK_EN
        else if (bus.ret_req) begin
          pc_load_c = 1'b1;
          if (stk_empty) begin
            stk_err_c = 1'b1;
          end else begin
            pc_load_value_c = stk_top;
            sp_d            = sp_q - SP_W'(1);
          end
        end else if (bus.call_req) begin
          pc_load_c = 1'b1;
          if (stk_full) begin
            stk_err_c = 1'b1;
          end else begin
            pc_load_value_c = bus.jump_addr;
            push_c          = 1'b1;
            sp_d            = sp_q + SP_W'(1);
          end
        end
`else
        // Without the stack a call degenerates to a jump and ret falls through.
        else if (bus.call_req) begin
          pc_load_c       = 1'b1;
          pc_load_value_c = bus.jump_addr;
        end
`endif
        else if (bus.jump_req) begin
          pc_load_c       = 1'b1;
          pc_load_value_c = bus.jump_addr;
        end else if (bus.halt_req) begin
          pc_load_c = 1'b1;
          hret_d    = state_q;
          state_d   = ST_HALT;
        end else if (bus.stall) begin
          pc_load_c = 1'b1;
        end
      end
    endcase

    // Reset takes effect on the outputs immediately, not at the next edge.
    if (reset) begin
      pc_load_c       = 1'b1;
      pc_load_value_c = BOOT_ADDR;
      irq_ack_c       = 1'b0;
      stk_err_c       = 1'b0;
    end
  end

  assign bus.pc_load       = pc_load_c;
  assign bus.pc_load_value = pc_load_value_c;
  assign bus.irq_ack       = irq_ack_c;
  assign bus.stk_err       = stk_err_c;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random requests, checked against a queue-based model.
module tb_pc_sequencer;

  localparam logic [3:0] BOOT = 4'h3;
  localparam logic [3:0] IRQV = 4'hC;

  localparam logic [1:0] M_BOOT = 2'b00;
  localparam logic [1:0] M_RUN  = 2'b01;
  localparam logic [1:0] M_IRQ  = 2'b10;
  localparam logic [1:0] M_HALT = 2'b11;

`ifdef PC_SEQ_RETSTACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(.BOOT_ADDR(BOOT), .IRQ_VECTOR(IRQV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External PC register closed around the sequencer.
  logic [3:0] pc_q;
  always @(posedge clk or posedge reset) begin
    if (reset) pc_q <= 4'h0;
    else       pc_q <= bus.pc_load ? bus.pc_load_value : pc_q + 4'h1;
  end
  assign bus.pc_value = pc_q;

  // Request stimulus applied at each falling edge.
  logic       r_reset, r_irq, r_iret, r_call, r_ret, r_jump, r_halt, r_resume, r_stall;
  logic [3:0] r_ja;

  // Reference model state.
  logic [1:0] m_mode;
  logic [1:0] m_hret;
  logic [3:0] m_epc;
  logic [3:0] m_pc;
  logic [3:0] m_stk[$];

  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] inc4(input logic [3:0] v);
    return 4'((int'(v) + 1) % 16);
  endfunction

  task automatic clear_reqs();
    r_irq = 0; r_iret = 0; r_call = 0; r_ret = 0; r_jump = 0;
    r_halt = 0; r_resume = 0; r_stall = 0; r_ja = 4'h0;
  endtask

  // One clock cycle: drive, predict, compare away from the edge, then advance the model.
  task automatic step(input string tag);
    logic       e_load, e_ack, e_err, push, pop;
    logic [3:0] e_val;
    logic [1:0] n_mode, n_hret;
    logic [3:0] n_epc;
    @(negedge clk);
    reset          = r_reset;
    bus.irq_req    = r_irq;
    bus.iret_req   = r_iret;
    bus.call_req   = r_call;
    bus.ret_req    = r_ret;
    bus.jump_req   = r_jump;
    bus.jump_addr  = r_ja;
    bus.halt_req   = r_halt;
    bus.resume_req = r_resume;
    bus.stall      = r_stall;
    #1;
    if (r_reset) begin
      m_mode = M_BOOT; m_hret = M_RUN; m_epc = 4'h0; m_pc = 4'h0; m_stk.delete();
    end
    e_load = 1; e_val = m_pc; e_ack = 0; e_err = 0; push = 0; pop = 0;
    n_mode = m_mode; n_hret = m_hret; n_epc = m_epc;
    if (r_reset) begin
      e_val = BOOT;
    end else if (m_mode == M_BOOT) begin
      e_val = BOOT; n_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      if (r_resume) n_mode = m_hret;
    end else if (r_irq && m_mode == M_RUN) begin
      e_val = IRQV; e_ack = 1; n_epc = inc4(m_pc); n_mode = M_IRQ;
    end else if (r_iret && m_mode == M_IRQ) begin
      e_val = m_epc; n_mode = M_RUN;
    end else if (r_ret && STK_EN) begin
      if (m_stk.size() == 0) e_err = 1;
      else begin e_val = m_stk[$]; pop = 1; end
    end else if (r_call && STK_EN) begin
      if (m_stk.size() == 4) e_err = 1;
      else begin e_val = r_ja; push = 1; end
    end else if (r_call || r_jump) begin
      e_val = r_ja;
    end else if (r_halt) begin
      n_hret = m_mode; n_mode = M_HALT;
    end else if (!r_stall) begin
      e_load = 0;
    end
    chk({tag, ".pc"},        8'(pc_q),              8'(m_pc));
    chk({tag, ".state"},     8'(bus.state),         8'(m_mode));
    chk({tag, ".pc_load"},   8'(bus.pc_load),       8'(e_load));
    chk({tag, ".load_val"},  8'(bus.pc_load_value), 8'(e_val));
    chk({tag, ".irq_ack"},   8'(bus.irq_ack),       8'(e_ack));
    chk({tag, ".stk_err"},   8'(bus.stk_err),       8'(e_err));
    @(posedge clk);
    if (!r_reset) begin
      if (push) m_stk.push_back(inc4(m_pc));
      if (pop)  void'(m_stk.pop_back());
      m_pc   = e_load ? e_val : inc4(m_pc);
      m_mode = n_mode; m_hret = n_hret; m_epc = n_epc;
    end
  endtask

  initial begin
    logic [3:0] pc0;
    n_chk = 0; n_fail = 0;
    clear_reqs();
    r_reset = 1;
    bus.irq_req = 0; bus.iret_req = 0; bus.call_req = 0; bus.ret_req = 0;
    bus.jump_req = 0; bus.jump_addr = 0; bus.halt_req = 0; bus.resume_req = 0; bus.stall = 0;
    m_mode = M_BOOT; m_hret = M_RUN; m_epc = 0; m_pc = 0; m_stk.delete();

    step("reset"); step("reset");

    // Boot then free-running count 3,4,5,6.
    r_reset = 0;
    step("boot");
    repeat (3) step("count");
    #1; chk("count.pc6", 8'(pc_q), 8'h6); chk("count.run", 8'(bus.state), 8'(M_RUN));

    // Interrupt taken at 4'hF: return PC wraps to 0.
    r_jump = 1; r_ja = 4'hF; step("jmpF");
    clear_reqs(); r_irq = 1; step("irqF");
    clear_reqs(); #1; chk("irqF.pc", 8'(pc_q), 8'hC); chk("irqF.state", 8'(bus.state), 8'(M_IRQ));
    step("isr");
    r_iret = 1; step("iret");
    clear_reqs(); #1; chk("iret.pc", 8'(pc_q), 8'h0); chk("iret.state", 8'(bus.state), 8'(M_RUN));

    // Nested irq ignored; jump wins over stall.
    r_irq = 1; step("irq");
    r_jump = 1; r_ja = 4'h7; r_stall = 1; step("irq+jmp");
    clear_reqs(); #1; chk("irq+jmp.pc", 8'(pc_q), 8'h7); chk("irq+jmp.state", 8'(bus.state), 8'(M_IRQ));

    // Halt inside IRQ, jumps ignored, resume back to IRQ.
    r_jump = 1; r_ja = 4'h5; step("jmp5");
    clear_reqs(); r_halt = 1; step("halt");
    clear_reqs(); r_jump = 1; r_ja = 4'h9;
    repeat (10) step("halted");
    #1; chk("halted.pc", 8'(pc_q), 8'h5);
    clear_reqs(); r_resume = 1; step("resume");
    clear_reqs(); #1; chk("resume.state", 8'(bus.state), 8'(M_IRQ));
    step("post_resume");
    #1; chk("resume.pc6", 8'(pc_q), 8'h6);

    // Asynchronous reset while halted acts before the next edge.
    r_halt = 1; step("halt2");
    clear_reqs();
    #2; reset = 1'b1; #1;
    chk("async_rst.state", 8'(bus.state), 8'(M_BOOT));
    chk("async_rst.val",   8'(bus.pc_load_value), 8'(BOOT));
    chk("async_rst.load",  8'(bus.pc_load), 8'h1);
    r_reset = 1; step("rst2");
    r_reset = 0; step("boot2"); step("run2");

`ifdef PC_SEQ_RETSTACK_EN
    // Fill the stack, overflow, unwind LIFO, underflow.
    pc0 = m_pc;
    for (int k = 1; k <= 5; k++) begin
      clear_reqs(); r_call = 1; r_ja = 4'(k); step("call");
    end
    clear_reqs(); #1; chk("call5.hold", 8'(pc_q), 8'h4);
    for (int k = 0; k < 5; k++) begin
      clear_reqs(); r_ret = 1; step("ret");
      #1;
      if (k < 3) chk("ret.lifo", 8'(pc_q), 8'(4 - k));
      else if (k == 3) chk("ret.base", 8'(pc_q), 8'(inc4(pc0)));
      else chk("ret5.hold", 8'(pc_q), 8'(inc4(pc0)));
    end
    clear_reqs();
`else
    pc0 = 4'h0;
    r_call = 1; r_ja = 4'hA; step("call_as_jump");
    clear_reqs(); #1; chk("call_as_jump.pc", 8'(pc_q), 8'hA);
    r_ret = 1; step("ret_ignored");
    clear_reqs(); #1; chk("ret_ignored.pc", 8'(pc_q + pc0), 8'hB);
`endif

    // Random request mix.
    for (int i = 0; i < 600; i++) begin
      r_reset  = ($urandom_range(63) == 0);
      r_irq    = ($urandom_range(7) == 0);
      r_iret   = ($urandom_range(5) == 0);
      r_call   = ($urandom_range(7) == 0);
      r_ret    = ($urandom_range(6) == 0);
      r_jump   = ($urandom_range(5) == 0);
      r_ja     = 4'($urandom_range(15));
      r_halt   = ($urandom_range(15) == 0);
      r_resume = ($urandom_range(3) == 0);
      r_stall  = ($urandom_range(5) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
